sm3_block_scheduler: RTL
========================

Name: sm3_block_scheduler

Overview:
- Sequences the SM3 message-expansion unit and the SM3 compression rounds for one message of one or more 512-bit padded blocks.
- Accepts blocks from the accelerator's CPU-side interface through a valid/ready handshake and latches each block into the expansion input.
- Pulses the expansion enable per block and, from the expansion step counter, generates round-enable and chaining-update strobes for compression.
- Signals hash completion after the last block.

Parameters:
- BLK_W, 512, padded block width.
- STEP_W, 7, width of the expansion step counter.
- TIMEOUT, 32, cycle limit in EXPAND (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- blk_valid  in  1  block offered
- blk_ready  out  1  scheduler can accept a block
- blk_data  in  BLK_W  padded block
- blk_last  in  1  block is the final block of the message
- abort  in  1  drop the current message
- exp_en  out  1  enable to the expansion unit
- exp_padded  out  BLK_W  latched block to the expansion unit
- exp_step  in  STEP_W  expansion step (0,4..60 valid; 64 idle; 65 finished)
- cmp_round_en  out  1  compression consumes the 4 words this cycle
- cmp_first  out  1  current block is the first of the message (compression loads IV)
- cmp_update  out  1  one-cycle pulse: V <= V xor ABCDEFGH
- hash_valid  out  1  one-cycle pulse: digest final
- err  out  1  sticky protocol error

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values: exp_en=0, exp_padded=0, cmp_update=0, hash_valid=0, err=0, first flag=1, round count=0, state IDLE.
- States: IDLE, EXPAND, UPDATE, DONE.
- IDLE:
  - blk_ready=1.
  - On blk_valid&&blk_ready: latch blk_data into exp_padded and blk_last into last_r; set exp_en=1; go to EXPAND.
- EXPAND:
  - exp_en held at 1; blk_ready=0.
  - cmp_round_en = (state==EXPAND) && exp_step<64. This is combinational, aligned with the registered expansion outputs.
  - The round count increments on each cmp_round_en.
  - When exp_step==65: go to UPDATE and set exp_en=0 at the same edge. If the round count is not 16 at that point, set err=1.
- UPDATE:
  - cmp_update=1 for exactly one cycle.
  - Clear the round count and the first flag.
  - If last_r: go to DONE. Otherwise go to IDLE.
- DONE:
  - hash_valid=1 for one cycle; the first flag is set to 1.
  - Go to IDLE.
- cmp_first = first flag, valid during EXPAND.
- Timing, with the handshake in cycle 0:
  - exp_en high from cycle 1.
  - exp_step=0 in cycle 2; rounds run in cycles 2..17 (steps 0..60).
  - exp_step=65 in cycle 18.
  - cmp_update in cycle 19.
  - hash_valid in cycle 20 (last block only).
  - Next block accepted no earlier than cycle 20 (non-last) or cycle 21 (last).
- exp_en is low for at least one cycle between blocks, which restarts the expansion counter.
- abort: highest priority after rst. At the next edge: go to IDLE, exp_en=0, round count=0, first flag=1, no cmp_update and no hash_valid. An abort in IDLE coincident with blk_valid rejects the block (blk_ready=0 that cycle).
- exp_step>=64 and !=65 in EXPAND after cycle 2 of the block: no action (stall tolerated).
- err: cleared only by rst.

Optional Feature:
- Macro SM3_SCHED_TIMEOUT_EN.
- When defined: a cycle counter runs in EXPAND. If TIMEOUT cycles elapse without exp_step==65, set err=1, force exp_en=0, and return to IDLE with the first flag set (message dropped, no cmp_update).
- When undefined: no counter; EXPAND waits indefinitely.

Decomposition:
- Shared package sm3_pkg holds:
  - state enum: IDLE/EXPAND/UPDATE/DONE
  - SM3_BLK_W=512
  - SM3_STEP_DONE=65
  - SM3_STEP_IDLE=64
  - SM3_ROUNDS_PER_BLK=16
- No sub-module: single FSM plus counters.

Test Plan:
- Single-block message "abc" padded block, blk_last=1 -> cmp_round_en high cycles 2..17 (16 cycles), cmp_update in cycle 19, hash_valid in cycle 20, cmp_first=1 throughout, err=0.
- Two-block message (first blk_last=0) -> first block cmp_first=1, second block cmp_first=0; two cmp_update pulses; one hash_valid, after the second cmp_update; exp_en low ≥1 cycle between blocks.
- blk_valid held high during EXPAND -> blk_ready=0; no re-latch; exp_padded unchanged until back in IDLE.
- abort asserted in cycle 10 of a block -> exp_en=0 next cycle; no cmp_update or hash_valid; next block accepted with cmp_first=1.
- Stub expansion returns 65 after 8 steps -> err=1 sticky; cmp_update still pulses; rst clears err.
- With SM3_SCHED_TIMEOUT_EN and TIMEOUT=32, stub exp_step stuck at 64 -> err=1 at cycle 33, state IDLE, blk_ready=1, no cmp_update.

Source files
------------

// File: rtl/sm3_pkg.sv
// Shared SM3 scheduler definitions: FSM states, block width, step codes, rounds per block.
package sm3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } sm3_state_e;

    localparam int unsigned SM3_BLK_W          = 512;
    localparam int unsigned SM3_STEP_IDLE      = 64;
    localparam int unsigned SM3_STEP_DONE      = 65;
    localparam int unsigned SM3_ROUNDS_PER_BLK = 16;
    localparam int unsigned SM3_RCNT_W         = 5;

endpackage

// File: rtl/sm3_block_scheduler.sv
// SM3 block scheduler: accepts padded blocks, drives the message-expansion unit and
// derives compression round/update strobes plus hash completion from its step counter.
// Optional build macro SM3_SCHED_TIMEOUT_EN adds an EXPAND watchdog of TIMEOUT cycles.
module sm3_block_scheduler
    import sm3_pkg::*;
#(
    parameter int unsigned BLK_W   = SM3_BLK_W,
    parameter int unsigned STEP_W  = 7,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [BLK_W-1:0]  blk_data,
    input  logic              blk_last,
    input  logic              abort,
    output logic              exp_en,
    output logic [BLK_W-1:0]  exp_padded,
    input  logic [STEP_W-1:0] exp_step,
    output logic              cmp_round_en,
    output logic              cmp_first,
    output logic              cmp_update,
    output logic              hash_valid,
    output logic              err
);

    sm3_state_e            r_state;
    logic                  r_exp_en;
    logic [BLK_W-1:0]      r_padded;
    logic                  r_last;
    logic                  r_first;
    logic                  r_update;
    logic                  r_hash_valid;
    logic                  r_err;
    logic [SM3_RCNT_W-1:0] r_rcnt;

    logic                  w_ready;
    logic                  w_round_en;
    logic                  w_step_done;
    logic                  w_timeout;

    assign w_ready     = (r_state == IDLE) && !abort;
    assign w_round_en  = (r_state == EXPAND) && (exp_step < STEP_W'(SM3_STEP_IDLE));
    assign w_step_done = (exp_step == STEP_W'(SM3_STEP_DONE));

`ifdef SM3_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;

    assign w_timeout = (r_state == EXPAND) && (r_to_cnt == TO_W'(TIMEOUT - 1));

    // Watchdog: counts cycles spent in EXPAND, restarts whenever EXPAND is left.
    always_ff @(posedge clk) begin
        if (rst || abort || (r_state != EXPAND)) begin
            r_to_cnt <= '0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    logic w_unused_timeout;

    // TIMEOUT only matters when the watchdog is built in.
    assign w_unused_timeout = |32'(TIMEOUT);
    assign w_timeout        = 1'b0;
`endif

    // Block sequencing FSM with registered strobes and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_exp_en     <= 1'b0;
            r_padded     <= '0;
            r_last       <= 1'b0;
            r_first      <= 1'b1;
            r_update     <= 1'b0;
            r_hash_valid <= 1'b0;
            r_err        <= 1'b0;
            r_rcnt       <= '0;
        end else if (abort) begin
            r_state      <= IDLE;
            r_exp_en     <= 1'b0;
            r_first      <= 1'b1;
            r_update     <= 1'b0;
            r_hash_valid <= 1'b0;
            r_rcnt       <= '0;
        end else begin
            r_update     <= 1'b0;
            r_hash_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (blk_valid && w_ready) begin
                        r_padded <= blk_data;
                        r_last   <= blk_last;
                        r_exp_en <= 1'b1;
                        r_state  <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (w_round_en && (r_rcnt != '1)) begin
                        r_rcnt <= r_rcnt + SM3_RCNT_W'(1);
                    end
                    if (w_step_done) begin
                        r_state  <= UPDATE;
                        r_exp_en <= 1'b0;
                        r_update <= 1'b1;
                        if (r_rcnt != SM3_RCNT_W'(SM3_ROUNDS_PER_BLK)) begin
                            r_err <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        // Expansion stalled too long: drop the message.
                        r_state  <= IDLE;
                        r_exp_en <= 1'b0;
                        r_err    <= 1'b1;
                        r_first  <= 1'b1;
                        r_rcnt   <= '0;
                    end
                end
                UPDATE: begin
                    r_rcnt  <= '0;
                    r_first <= 1'b0;
                    if (r_last) begin
                        r_state      <= DONE;
                        r_hash_valid <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DONE: begin
                    r_first <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign blk_ready    = w_ready;
    assign cmp_round_en = w_round_en;
    assign exp_en       = r_exp_en;
    assign exp_padded   = r_padded;
    assign cmp_first    = r_first;
    assign cmp_update   = r_update;
    assign hash_valid   = r_hash_valid;
    assign err          = r_err;

endmodule
